// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register writeback countdown plus load flag, driving decode stall/issue.
// Define REG_SCB_FORWARDING_EN to let ALU results and nearly-complete loads bypass the scoreboard.
module reg_scoreboard #(
    parameter int ADDR_WIDTH   = 4,
    parameter int ALU_WB_LAT   = 3,
    parameter int LOAD_WB_LAT  = 4,
    parameter int LOAD_FWD_CNT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dec_valid_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_1_i,
    input  logic [ADDR_WIDTH-1:0] reg_addr_2_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic                  use_src1_i,
    input  logic                  use_src2_i,
    input  logic                  writes_dest_i,
    input  logic                  is_load_i,
    input  logic                  pipe_hold_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  issue_o
);

    localparam int         NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [2:0] ALU_LAT  = 3'(ALU_WB_LAT);
    localparam logic [2:0] LOAD_LAT = 3'(LOAD_WB_LAT);
    localparam logic [2:0] FWD_CNT  = 3'(LOAD_FWD_CNT);
`ifdef REG_SCB_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0][2:0] cnt_q, cnt_d;
    logic [NUM_REGS-1:0]      ld_q, ld_d;
    logic [NUM_REGS-1:0]      blocked;
    logic                     src1_haz, src2_haz, hazard;
    logic [2:0]               wb_lat;

    // A register blocks a reader while busy, unless its value can already be forwarded.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            blocked[r] = (cnt_q[r] != 3'd0) &&
                         !(FWD_EN && (!ld_q[r] || (cnt_q[r] <= FWD_CNT)));
        end
    end

    always_comb begin
        src1_haz = use_src1_i & blocked[reg_addr_1_i];
        src2_haz = use_src2_i & blocked[reg_addr_2_i];
        hazard   = ~rst_i & (src1_haz | src2_haz);
        stall_o  = dec_valid_i & (pipe_hold_i | hazard);
        issue_o  = dec_valid_i & ~stall_o;
    end

    // Hazards above read pre-update state, so a producer never clears its own sources.
    always_comb begin
        cnt_d  = cnt_q;
        ld_d   = ld_q;
        wb_lat = is_load_i ? LOAD_LAT : ALU_LAT;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush_i) begin
                cnt_d[r] = 3'd0;
                ld_d[r]  = 1'b0;
            end else if (!pipe_hold_i) begin
                cnt_d[r] = (cnt_q[r] != 3'd0) ? (cnt_q[r] - 3'd1) : 3'd0;
                if (issue_o && writes_dest_i && (reg_dest_addr_i == ADDR_WIDTH'(r))) begin
                    if (cnt_d[r] < wb_lat) begin
                        cnt_d[r] = wb_lat;
                    end
                    ld_d[r] = is_load_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ld_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ld_q  <= ld_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each step queues the expected {stall, issue} pair and
// checks it mid-cycle; expectations follow the REG_SCB_FORWARDING_EN build setting.
module tb_reg_scoreboard;

    localparam int AW = 4;
`ifdef REG_SCB_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Stall cycles seen by a consumer presented the cycle after a load / ALU producer.
    localparam int LOAD_STALLS = FWD ? 3 : 4;
    localparam int ALU_STALLS  = FWD ? 0 : 3;

    logic          clk;
    logic          rst;
    logic          decValid;
    logic [AW-1:0] addr1, addr2, destAddr;
    logic          useSrc1, useSrc2, writesDest, isLoad;
    logic          pipeHold, flush;
    logic          stall, issue;

    logic [1:0]    expQ[$];
    string         tagQ[$];
    int            testsRun;
    int            testsFailed;

    reg_scoreboard #(
        .ADDR_WIDTH  (AW),
        .ALU_WB_LAT  (3),
        .LOAD_WB_LAT (4),
        .LOAD_FWD_CNT(1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .dec_valid_i    (decValid),
        .reg_addr_1_i   (addr1),
        .reg_addr_2_i   (addr2),
        .reg_dest_addr_i(destAddr),
        .use_src1_i     (useSrc1),
        .use_src2_i     (useSrc2),
        .writes_dest_i  (writesDest),
        .is_load_i      (isLoad),
        .pipe_hold_i    (pipeHold),
        .flush_i        (flush),
        .stall_o        (stall),
        .issue_o        (issue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: time observed 20000 required below 20000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput();
        logic [1:0] expSI;
        string      tag;
        expSI = expQ.pop_front();
        tag   = tagQ.pop_front();
        testsRun++;
        assert ({stall, issue} === expSI) else begin
            testsFailed++;
            $error("[TB] FAIL %s: stall/issue observed %b required %b", tag, {stall, issue}, expSI);
        end
        testsRun++;
        assert (!(stall && issue)) else begin
            testsFailed++;
            $error("[TB] FAIL %s_excl: stall&issue observed 1 required 0", tag);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] dst, input logic u1, input logic u2,
                                 input logic wd, input logic ld, input logic hold,
                                 input logic fl, input logic rs, input logic [1:0] expSI,
                                 input string tag);
        decValid   = v;
        addr1      = a1;
        addr2      = a2;
        destAddr   = dst;
        useSrc1    = u1;
        useSrc2    = u2;
        writesDest = wd;
        isLoad     = ld;
        pipeHold   = hold;
        flush      = fl;
        rst        = rs;
        expQ.push_back(expSI);
        tagQ.push_back(tag);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          2'b00, "idle");
        end
    endtask

    task automatic produce(input logic [AW-1:0] dst, input logic ld, input string tag);
        applyStimulus(1'b1, 4'd0, 4'd0, dst, 1'b0, 1'b0, 1'b1, ld, 1'b0, 1'b0, 1'b0,
                      2'b01, tag);
    endtask

    // Present a reader every cycle: nStall stalls followed by one issue.
    task automatic consume(input logic [AW-1:0] src, input int nStall, input logic both,
                           input string tag);
        for (int i = 0; i <= nStall; i++) begin
            applyStimulus(1'b1, src, both ? src : 4'd0, 4'd0, 1'b1, both, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, (i < nStall) ? 2'b10 : 2'b01,
                          $sformatf("%s_c%0d", tag, i));
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        decValid    = 1'b0;
        addr1       = '0;
        addr2       = '0;
        destAddr    = '0;
        useSrc1     = 1'b0;
        useSrc2     = 1'b0;
        writesDest  = 1'b0;
        isLoad      = 1'b0;
        pipeHold    = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        #1;

        // Reset: hazards masked, a load issued under reset leaves no trace.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                      2'b01, "rst_issue");
        applyStimulus(1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                      2'b10, "rst_hold");
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      2'b00, "rst_idle");
        consume(4'd2, 0, 1'b0, "post_rst_r2");

        // Load-use and ALU-use latency.
        produce(4'd2, 1'b1, "ld_r2");
        consume(4'd2, LOAD_STALLS, 1'b0, "use_r2");
        idle(5);
        produce(4'd1, 1'b0, "alu_r1");
        consume(4'd1, ALU_STALLS, 1'b0, "use_r1");
        idle(4);

        // Hold freezes the countdown for two cycles.
        produce(4'd3, 1'b1, "ld_r3");
        applyStimulus(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      2'b10, "hold_r3_a");
        applyStimulus(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      2'b10, "hold_r3_b");
        consume(4'd3, LOAD_STALLS, 1'b0, "use_r3");
        idle(5);

        // Flush clears state and suppresses that cycle's destination update.
        produce(4'd4, 1'b1, "ld_r4");
        applyStimulus(1'b1, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                      2'b10, "flush_r4");
        consume(4'd4, 0, 1'b0, "use_r4_flush");
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                      2'b01, "flush_ld_r6");
        consume(4'd6, 0, 1'b0, "use_r6_flush");

        // Reset in place of flush, and reset arriving mid-stall.
        produce(4'd4, 1'b1, "ld_r4_again");
        applyStimulus(1'b1, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      2'b01, "rst_r4");
        consume(4'd4, 0, 1'b0, "use_r4_rst");
        produce(4'd7, 1'b1, "ld_r7");
        applyStimulus(1'b1, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      2'b10, "stall_r7");
        applyStimulus(1'b1, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                      2'b10, "rst_hold_r7");
        consume(4'd7, 0, 1'b0, "use_r7_rst");

        // Back-to-back writers of one register: later writer sets latency and load flag.
        produce(4'd5, 1'b1, "ld_r5");
        applyStimulus(1'b1, 4'd8, 4'd9, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      2'b01, "alu_r5_waw");
        consume(4'd5, ALU_STALLS, 1'b0, "use_r5");
        idle(4);
        produce(4'd14, 1'b0, "alu_r14");
        produce(4'd14, 1'b1, "ld_r14_waw");
        consume(4'd14, LOAD_STALLS, 1'b0, "use_r14");
        idle(5);

        // Source equal to own destination sees prior state only.
        applyStimulus(1'b1, 4'd11, 4'd0, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                      2'b01, "self_ld_r11");
        consume(4'd11, LOAD_STALLS, 1'b0, "use_r11");
        idle(5);

        // Both sources on one busy register.
        produce(4'd12, 1'b1, "ld_r12");
        consume(4'd12, LOAD_STALLS, 1'b1, "both_r12");
        idle(5);

        // Usage qualifiers, invalid decode and hold without hazards.
        produce(4'd13, 1'b1, "ld_r13");
        applyStimulus(1'b1, 4'd13, 4'd13, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      2'b01, "unused_src_r13");
        applyStimulus(1'b1, 4'd0, 4'd13, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      2'b10, "src2_r13");
        applyStimulus(1'b0, 4'd13, 4'd13, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      2'b00, "invalid_busy_r13");
        idle(5);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      2'b10, "hold_only");
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      2'b00, "hold_idle");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
